// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding
// and default sizing.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CW    = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/seq_divider_step.sv
// One non-restoring division row: shift {p, a} left, then add or subtract the
// divisor depending on the sign of the incoming partial remainder.
module nr_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] a_next
);

  logic [WIDTH:0] p_sh;
  logic [WIDTH:0] d_ext;
  logic [WIDTH:0] sum;
  logic           sub;

  // Controlled add/subtract cell: invert d and inject a carry to subtract.
  always_comb begin
    p_sh   = {p[WIDTH-1:0], a[WIDTH-1]};
    sub    = ~p[WIDTH];
    d_ext  = {1'b0, d} ^ {(WIDTH + 1){sub}};
    sum    = p_sh + d_ext + {{WIDTH{1'b0}}, sub};
    p_next = sum;
    a_next = {a[WIDTH-2:0], ~sum[WIDTH]};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: one non-restoring row reused for WIDTH cycles,
// followed by a remainder-correction/sign-fix cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = DEFAULT_CW
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output div_state_e       state_dbg
);

  // Handshake: start is accepted only in IDLE; busy is high in ITER and FIX;
  // done pulses for exactly one cycle, and q, r, dbz are valid from that cycle
  // and held until the next accepted operation completes or clear.

  div_state_e       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] d_reg;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] r_mag;

  nr_div_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_reg),
    .a      (a_reg),
    .d      (d_reg),
    .p_next (p_next),
    .a_next (a_next)
  );

  // Final correction lands in [0, d), so WIDTH-bit arithmetic is exact.
  assign r_mag     = p_reg[WIDTH] ? (p_reg[WIDTH-1:0] + d_reg) : p_reg[WIDTH-1:0];
  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      dbz    <= 1'b0;
      q      <= '0;
      r      <= '0;
      cnt    <= '0;
      p_reg  <= '0;
      a_reg  <= '0;
      d_reg  <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              q     <= '1;
              r     <= dividend;
              dbz   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              a_reg  <= dividend[WIDTH-1] ? -dividend : dividend;
              d_reg  <= divisor[WIDTH-1] ? -divisor : divisor;
              sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              sign_r <= dividend[WIDTH-1];
              p_reg  <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= ITER;
            end
          end
        end
        ITER: begin
          p_reg <= p_next;
          a_reg <= a_next;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          q     <= sign_q ? -a_reg : a_reg;
          r     <= sign_r ? -r_mag : r_mag;
          dbz   <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: driver issues vectors and queues expected
// {dbz, q, r} plus latency; a negedge monitor checks each done pulse.
module tb_seq_divider;
  import seq_divider_pkg::*;

  localparam int W    = 32;
  localparam int EXPW = 2 * W + 1;

  logic         clock;
  logic         clear;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         dbz;
  logic [W-1:0] q;
  logic [W-1:0] r;
  div_state_e   state_dbg;

  logic [EXPW-1:0] exp_q[$];
  int              lat_q[$];
  int              n_cmp;
  int              n_err;
  int              cyc;
  int              accept_cyc;

  seq_divider #(.WIDTH(W), .CW(6)) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz),
    .q         (q),
    .r         (r),
    .state_dbg (state_dbg)
  );

  // Clock / cycle counter
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (got running, need finished)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [EXPW-1:0] got, input logic [EXPW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        logic [EXPW-1:0] want;
        int              want_lat;
        want     = exp_q.pop_front();
        want_lat = lat_q.pop_front();
        check("result{dbz,q,r}", {dbz, q, r}, want);
        check("latency", EXPW'(cyc - accept_cyc + 1), EXPW'(want_lat));
      end
    end
  end

  // Driver. mode: 0 plain, 1 check busy profile, 2 re-pulse start at cycle 10,
  // 3 clear at cycle 10 (no result expected).
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input int elat, input int mode);
    bit seen;
    seen = 1'b0;
    if (mode != 3) begin
      exp_q.push_back({edbz, eq, er});
      lat_q.push_back(elat);
    end
    @(negedge clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock);
    #1;
    accept_cyc = cyc;
    start      = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (mode == 1 && k <= 34) begin
        check($sformatf("busy_c%0d", k), EXPW'(busy), EXPW'(k <= 33));
      end
      if (mode == 2 && k == 10) begin
        dividend = 32'd50;
        divisor  = 32'd3;
        start    = 1'b1;
      end
      if (mode == 2 && k == 11) begin
        start    = 1'b0;
        dividend = 32'd1234;
        divisor  = 32'd5;
      end
      if (mode == 3 && k == 10) clear = 1'b1;
      if (mode == 3 && k == 11) begin
        clear = 1'b0;
        check("abort_busy", EXPW'(busy), '0);
        check("abort_done", EXPW'(done), '0);
        check("abort_qr", EXPW'({q, r}), '0);
      end
      if (mode == 3 && k == 45) break;
      if (mode != 3 && done === 1'b1) begin
        seen = 1'b1;
        @(negedge clock);
        check("done_pulse_width", EXPW'(done), '0);
        break;
      end
    end
    if (mode != 3 && !seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done in 60 cycles, expected done at %0d", elat);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    clear    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    accept_cyc = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", EXPW'({busy, done, dbz}), '0);
    check("reset_qr", EXPW'({q, r}), '0);
    check("reset_state", EXPW'(state_dbg), EXPW'(IDLE));
    clear = 1'b0;

    run_div(32'd100,        32'd7,        32'd14,        32'd2,        1'b0, 34, 1);
    run_div(32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2,  32'hFFFFFFFE, 1'b0, 34, 0);
    run_div(32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2,  32'd2,        1'b0, 34, 0);
    run_div(32'hFFFFFFF9,   32'hFFFFFFFE, 32'd3,         32'hFFFFFFFF, 1'b0, 34, 0);
    run_div(32'd7,          32'd0,        32'hFFFFFFFF,  32'd7,        1'b1, 1,  0);
    run_div(32'd8,          32'd2,        32'd4,         32'd0,        1'b0, 34, 0);
    run_div(32'hFFFFFFFB,   32'd0,        32'hFFFFFFFF,  32'hFFFFFFFB, 1'b1, 1,  0);
    run_div(32'h80000000,   32'hFFFFFFFF, 32'h80000000,  32'd0,        1'b0, 34, 0);
    run_div(32'h80000000,   32'd1,        32'h80000000,  32'd0,        1'b0, 34, 0);
    run_div(32'h7FFFFFFF,   32'h80000000, 32'd0,         32'h7FFFFFFF, 1'b0, 34, 0);
    run_div(32'd0,          32'd5,        32'd0,         32'd0,        1'b0, 34, 0);
    run_div(32'd100,        32'd7,        32'd14,        32'd2,        1'b0, 34, 2);
    run_div(32'd100,        32'd7,        32'd0,         32'd0,        1'b0, 0,  3);
    run_div(32'd9,          32'd4,        32'd2,         32'd1,        1'b0, 34, 0);

    repeat (5) @(negedge clock);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL leftover_expected: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
